// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - memory-mapped 8N1 UART transmitter with a 16-entry TX FIFO
//
// Purpose:
//   A CPU store pushes a byte into the TX FIFO. The transmitter pops bytes and
//   serialises each one as 8N1, LSB first, on the TX pin. Frames run back to back
//   while the FIFO has data. A status load reports the FIFO level and busy state.
//
// Ports:
//   clk                    in   1   system clock
//   rst                    in   1   synchronous, active-high reset
//   write_enable           in   1   store strobe; pushes write_data[7:0]
//   write_data             in   32  store data; bits [31:8] ignored
//   status_read_enable     in   1   status load strobe
//   status_data            out  32  {23'b0, count, 1'b0, busy, full, empty}; Z when not enabled
//   uart_tx_serial_output  out  1   TX line, idle high

module uart_tx_fifo #(
  parameter int BAUD_DIV   = 10416,
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  input  logic        status_read_enable,
  output logic [31:0] status_data,
  output logic        uart_tx_serial_output
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic [BW-1:0]    baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shifter;

  logic full;
  logic empty;
  logic busy;
  logic baud_end;
  logic push;
  logic pop;

  assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign baud_end = (baud_cnt == BAUD_LAST);

  // A full FIFO rejects the write outright, even if a pop frees a slot on the
  // same edge.
  assign push = write_enable && !full;
  // The transmitter takes a new byte from IDLE immediately, or at the end of a
  // stop bit so consecutive frames have no idle gap.
  assign pop  = !empty && ((state == IDLE) || ((state == STOP) && baud_end));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail] <= write_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      uart_tx_serial_output <= 1'b1;
      baud_cnt              <= '0;
      bit_cnt               <= '0;
      shifter               <= '0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx_serial_output <= 1'b1;
          if (pop) begin
            shifter               <= fifo_mem[head];
            uart_tx_serial_output <= 1'b0;
            baud_cnt              <= '0;
            state                 <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt              <= '0;
            uart_tx_serial_output <= shifter[0];
            bit_cnt               <= '0;
            state                 <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              uart_tx_serial_output <= 1'b1;
              state                 <= STOP;
            end else begin
              // shifter[0] is the bit on the line; shifter[1] is the next one.
              shifter               <= {1'b0, shifter[7:1]};
              uart_tx_serial_output <= shifter[1];
              bit_cnt               <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shifter               <= fifo_mem[head];
              uart_tx_serial_output <= 1'b0;
              state                 <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state                 <= IDLE;
          uart_tx_serial_output <= 1'b1;
        end
      endcase
    end
  end

  assign status_data = status_read_enable ? 32'({count, 1'b0, busy, full, empty}) : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a frame-decoding scoreboard

module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_enable;
  logic [31:0] write_data;
  logic        status_read_enable;
  wire  [31:0] status_data;
  logic        uart_tx_serial_output;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] sb [$];
  bit         rx_abort = 1'b0;
  bit         rx_busy  = 1'b0;
  int         rx_cnt   = 0;
  logic [7:0] rx_byte  = 8'h00;
  logic [7:0] rx_exp;

  uart_tx_fifo #(
    .BAUD_DIV   (4),
    .FIFO_DEPTH (16),
    .PTR_W      (4)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .write_enable          (write_enable),
    .write_data            (write_data),
    .status_read_enable    (status_read_enable),
    .status_data           (status_data),
    .uart_tx_serial_output (uart_tx_serial_output)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Frame decoder: start found on the first low sample, data bits sampled one
  // negedge into each 4-cycle bit, stop bit sampled near its middle.
  always @(negedge clk) begin
    if (rx_abort || rst) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (uart_tx_serial_output === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == 2) check("rx_start_bit", {31'b0, uart_tx_serial_output}, 32'd0);
      if (rx_cnt >= 5 && rx_cnt <= 33 && ((rx_cnt - 5) % 4) == 0)
        rx_byte = {uart_tx_serial_output, rx_byte[7:1]};
      if (rx_cnt == 37) begin
        check("rx_stop_bit", {31'b0, uart_tx_serial_output}, 32'd1);
        check("rx_frame_expected", {31'b0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) begin
          rx_exp = sb.pop_front();
          check("rx_byte", {24'b0, rx_byte}, {24'b0, rx_exp});
        end
        rx_busy = 1'b0;
      end
    end
  end

  task automatic write_byte(input logic [31:0] d);
    write_enable = 1'b1;
    write_data   = d;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (status_data[2:0] !== 3'b001 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, status_data, 32'h0000_0001);
    check({tag, "_sb_drained"}, sb.size(), 32'd0);
  endtask

  initial begin
    logic [9:0] fr;
    int         n;
    bit         quiet;

    rst                = 1'b1;
    write_enable       = 1'b0;
    write_data         = '0;
    status_read_enable = 1'b1;

    // 1. reset state
    repeat (3) @(negedge clk);
    check("reset_status", status_data, 32'h0000_0001);
    check("reset_line", {31'b0, uart_tx_serial_output}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_status", status_data, 32'h0000_0001);

    // 2. single byte 0x55, bit-exact waveform
    sb.push_back(8'h55);
    write_byte(32'hDEAD_BE55);
    check("latency_line_high", {31'b0, uart_tx_serial_output}, 32'd1);
    fr = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check($sformatf("wave55_cyc%0d", i), {31'b0, uart_tx_serial_output}, {31'b0, fr[i/4]});
    end
    check("busy_at_cycle40", {31'b0, status_data[2]}, 32'd1);
    @(negedge clk);
    check("line_after_frame", {31'b0, uart_tx_serial_output}, 32'd1);
    check("status_after_frame", status_data, 32'h0000_0001);

    // 3. two back-to-back frames
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    write_byte(32'h0000_00A5);
    write_byte(32'h0000_003C);
    n = 0;
    while (status_data[2] === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("two_frame_cycles", n, 32'd80);
    wait_idle(20, "two_frames_idle");

    // 4. overflow burst: 0x00..0x13, last three dropped
    for (int i = 0; i < 20; i++) begin
      write_enable = 1'b1;
      write_data   = 32'(i);
      if (i <= 16) sb.push_back(8'(i));
      @(negedge clk);
    end
    write_enable = 1'b0;
    check("burst_status_full", status_data, 32'h0000_0106);
    wait_idle(2000, "burst_idle");

    // 5. reset mid-DATA with three bytes queued
    for (int i = 0; i < 4; i++) begin
      write_enable = 1'b1;
      write_data   = 32'h11 * (i + 1);
      sb.push_back(8'(32'h11 * (i + 1)));
      @(negedge clk);
    end
    write_enable = 1'b0;
    check("pre_rst_status", status_data, 32'h0000_0034);
    repeat (20) @(negedge clk);
    rst      = 1'b1;
    rx_abort = 1'b1;
    @(negedge clk);
    check("rst_line_high", {31'b0, uart_tx_serial_output}, 32'd1);
    check("rst_status", status_data, 32'h0000_0001);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    rx_abort = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_tx_serial_output !== 1'b1) quiet = 1'b0;
    end
    check("no_frame_after_rst", {31'b0, quiet}, 32'd1);
    check("status_after_rst_quiet", status_data, 32'h0000_0001);

    // 6. push on the same edge STOP pops the last queued byte
    sb.push_back(8'h5A);
    sb.push_back(8'hC3);
    sb.push_back(8'h96);
    write_byte(32'h0000_005A);
    write_byte(32'h0000_00C3);
    repeat (39) @(negedge clk);
    check("pre_stop_end_status", status_data, 32'h0000_0014);
    write_byte(32'h0000_0096);
    check("push_pop_count", status_data, 32'h0000_0014);
    wait_idle(300, "push_pop_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
